// File: rtl/dumper_pkg.sv
// rtl/dumper_pkg.sv - shared types and constants for axi_burst_dumper
package dumper_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_AR,
    S_RD,
    S_TX,
    S_FIN
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [7:0] HDR_BYTE0  = 8'hA5;
  localparam logic [7:0] HDR_BYTE1  = 8'h5A;

  // ceil(log2(v)) for v in 1..128, sized for the AXI arsize field
  function automatic logic [2:0] clog2(input int unsigned v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if ((32'd1 << i) < v) r = r + 3'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dumper_beat_buf.sv
// rtl/dumper_beat_buf.sv - one-burst beat buffer with byte-select read port
module dumper_beat_buf #(
  parameter int unsigned BEAT_BYTES = 32,
  parameter int unsigned BURST_LEN  = 16,
  parameter int          MSB_FIRST  = 0,
  parameter int          BI_W       = 4,
  parameter int          BY_W       = 5
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [BI_W-1:0]         wr_addr,
  input  logic [BEAT_BYTES*8-1:0] wr_data,
  input  logic [BI_W-1:0]         rd_addr,
  input  logic [BY_W-1:0]         rd_byte,
  output logic [7:0]              rd_data
);

  logic [BEAT_BYTES*8-1:0] mem [BURST_LEN];
  logic [BEAT_BYTES*8-1:0] beat;
  logic [BY_W-1:0]         sel;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign beat = mem[rd_addr];
  // Serial order: index 0 maps to the lowest or the highest byte lane
  assign sel     = (MSB_FIRST != 0) ? (BY_W'(BEAT_BYTES - 1) - rd_byte) : rd_byte;
  assign rd_data = beat[sel*8 +: 8];

endmodule

// File: rtl/axi_burst_dumper.sv
// rtl/axi_burst_dumper.sv - AXI4 ring reader that streams bursts out byte-wise to a UART
// Optional dump header (A5 5A SEQ LEN) enabled by defining DUMPER_HEADER_EN.
module axi_burst_dumper
  import dumper_pkg::*;
#(
  parameter int unsigned BEAT_BYTES  = 32,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned TOTAL_BEATS = 416,
  parameter logic [31:0] RING_BASE   = 32'h0,
  parameter logic [31:0] RING_SIZE   = 32'h4000,
  parameter logic [3:0]  AXI_ID      = 4'h0,
  parameter int          MSB_FIRST   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    read_start,
  input  logic [31:0]             read_addr,
  output logic                    busy,
  output logic                    done,
  output logic                    start_drop,
  output logic                    resp_err,
  output logic [3:0]              arid,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [3:0]              rid,
  input  logic [BEAT_BYTES*8-1:0] rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready
);

  localparam int BI_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int BY_W = $clog2(BEAT_BYTES);
  localparam int CW   = $clog2(TOTAL_BEATS + 1);

  localparam logic [31:0]     BURST_BYTES = 32'(BURST_LEN * BEAT_BYTES);
  localparam logic [32:0]     RING_END    = {1'b0, RING_BASE} + {1'b0, RING_SIZE};
  localparam logic [CW-1:0]   LAST_CNT    = CW'(TOTAL_BEATS - BURST_LEN);
  localparam logic [CW-1:0]   BURST_CNT   = CW'(BURST_LEN);
  localparam logic [BI_W-1:0] LAST_IDX    = BI_W'(BURST_LEN - 1);
  localparam logic [BY_W-1:0] LAST_BYTE   = BY_W'(BEAT_BYTES - 1);

  state_t          state;
  logic [31:0]     cur_addr;
  logic            pend_valid;
  logic [31:0]     pend_addr;
  logic [CW-1:0]   beat_cnt;
  logic [BI_W-1:0] rd_idx;
  logic [BI_W-1:0] last_beat;
  logic [BI_W-1:0] tx_beat;
  logic [BY_W-1:0] tx_byte;
  logic [7:0]      buf_byte;
  logic            buf_we;
  logic [31:0]     addr_inc;
  logic [31:0]     next_addr;
  logic            unused_ok;

`ifdef DUMPER_HEADER_EN
  localparam logic [7:0] HDR_LEN = 8'((TOTAL_BEATS / BURST_LEN) % 256);
  logic [1:0] hdr_idx;
  logic [7:0] seq;
  logic [7:0] hdr_byte;

  always_comb begin
    hdr_byte = HDR_BYTE0;
    case (hdr_idx)
      2'd0: hdr_byte = HDR_BYTE0;
      2'd1: hdr_byte = HDR_BYTE1;
      2'd2: hdr_byte = seq;
      2'd3: hdr_byte = HDR_LEN;
      default: hdr_byte = HDR_BYTE0;
    endcase
  end

  assign tx_data = !tx_valid ? 8'h00 : ((state == S_HDR) ? hdr_byte : buf_byte);
`else
  assign tx_data = tx_valid ? buf_byte : 8'h00;
`endif

  // Ring wrap: the next burst address folds back by one ring size at the end
  assign addr_inc  = cur_addr + BURST_BYTES;
  assign next_addr = ({1'b0, addr_inc} >= RING_END) ? (addr_inc - RING_SIZE) : addr_inc;

  assign buf_we    = (state == S_RD) && rvalid && rready;
  assign unused_ok = ^{rid, 1'b0};

  dumper_beat_buf #(
    .BEAT_BYTES (BEAT_BYTES),
    .BURST_LEN  (BURST_LEN),
    .MSB_FIRST  (MSB_FIRST),
    .BI_W       (BI_W),
    .BY_W       (BY_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_addr (rd_idx),
    .wr_data (rdata),
    .rd_addr (tx_beat),
    .rd_byte (tx_byte),
    .rd_data (buf_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cur_addr   <= 32'h0;
      pend_valid <= 1'b0;
      pend_addr  <= 32'h0;
      beat_cnt   <= '0;
      rd_idx     <= '0;
      last_beat  <= '0;
      tx_beat    <= '0;
      tx_byte    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      start_drop <= 1'b0;
      resp_err   <= 1'b0;
      arid       <= 4'h0;
      araddr     <= 32'h0;
      arlen      <= 8'h0;
      arsize     <= 3'h0;
      arburst    <= 2'b00;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      tx_valid   <= 1'b0;
`ifdef DUMPER_HEADER_EN
      hdr_idx    <= 2'd0;
      seq        <= 8'h00;
`endif
    end else begin
      done       <= 1'b0;
      start_drop <= 1'b0;

      // Requests arriving outside IDLE go to the single pending slot
      if (read_start && (state != S_IDLE)) begin
        if (pend_valid) begin
          start_drop <= 1'b1;
        end else begin
          pend_valid <= 1'b1;
          pend_addr  <= read_addr;
        end
      end

      case (state)
        S_IDLE: begin
          if (pend_valid || read_start) begin
            cur_addr <= pend_valid ? pend_addr : read_addr;
            if (pend_valid) begin
              pend_valid <= read_start;
              pend_addr  <= read_addr;
            end
            busy     <= 1'b1;
            beat_cnt <= '0;
`ifdef DUMPER_HEADER_EN
            hdr_idx  <= 2'd0;
            tx_valid <= 1'b1;
            state    <= S_HDR;
`else
            state    <= S_AR;
`endif
          end
        end

        S_HDR: begin
`ifdef DUMPER_HEADER_EN
          if (tx_ready) begin
            hdr_idx <= hdr_idx + 2'd1;
            if (hdr_idx == 2'd3) begin
              tx_valid <= 1'b0;
              state    <= S_AR;
            end
          end
`else
          state <= S_AR;
`endif
        end

        S_AR: begin
          if (!arvalid) begin
            arvalid <= 1'b1;
            araddr  <= cur_addr;
            arlen   <= 8'(BURST_LEN - 1);
            arsize  <= clog2(BEAT_BYTES);
            arburst <= BURST_INCR;
            arid    <= AXI_ID;
          end else if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            rd_idx  <= '0;
            state   <= S_RD;
          end
        end

        S_RD: begin
          if (rvalid && rready) begin
            if (rresp != RESP_OKAY) resp_err <= 1'b1;
            if (rlast || (rd_idx == LAST_IDX)) begin
              rready    <= 1'b0;
              last_beat <= rd_idx;
              tx_beat   <= '0;
              tx_byte   <= '0;
              tx_valid  <= 1'b1;
              state     <= S_TX;
            end else begin
              rd_idx <= rd_idx + BI_W'(1);
            end
          end
        end

        S_TX: begin
          if (tx_ready) begin
            if (tx_byte == LAST_BYTE) begin
              tx_byte <= '0;
              if (tx_beat == last_beat) begin
                tx_valid <= 1'b0;
                cur_addr <= next_addr;
                beat_cnt <= beat_cnt + BURST_CNT;
                state    <= (beat_cnt == LAST_CNT) ? S_FIN : S_AR;
              end else begin
                tx_beat <= tx_beat + BI_W'(1);
              end
            end else begin
              tx_byte <= tx_byte + BY_W'(1);
            end
          end
        end

        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
`ifdef DUMPER_HEADER_EN
          seq   <= seq + 8'h01;
`endif
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_dumper.sv
// tb/tb_axi_burst_dumper.sv - self-checking bench with AXI slave model and byte scoreboard
module tb_axi_burst_dumper;

  localparam int BB     = 32;
  localparam int BL     = 16;
  localparam int TBEATS = 32;
`ifdef DUMPER_HEADER_EN
  localparam int HDR_BYTES = 4;
  localparam int EXP_LAT   = 6;
`else
  localparam int HDR_BYTES = 0;
  localparam int EXP_LAT   = 2;
`endif
  localparam int DUMP_BYTES = TBEATS * BB + HDR_BYTES;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            read_start = 1'b0;
  logic [31:0]     read_addr = 32'h0;
  logic            busy, done, start_drop, resp_err;
  logic [3:0]      arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid, arready;
  logic [3:0]      rid;
  logic [BB*8-1:0] rdata;
  logic [1:0]      rresp;
  logic            rlast, rvalid, rready;
  logic [7:0]      tx_data;
  logic            tx_valid, tx_ready;

  always #5 clk = ~clk;

  axi_burst_dumper #(
    .BEAT_BYTES (BB), .BURST_LEN (BL), .TOTAL_BEATS (TBEATS),
    .RING_BASE (32'h0), .RING_SIZE (32'h4000), .AXI_ID (4'h0), .MSB_FIRST (0)
  ) dut (
    .clk (clk), .rst_n (rst_n), .read_start (read_start), .read_addr (read_addr),
    .busy (busy), .done (done), .start_drop (start_drop), .resp_err (resp_err),
    .arid (arid), .araddr (araddr), .arlen (arlen), .arsize (arsize), .arburst (arburst),
    .arvalid (arvalid), .arready (arready),
    .rid (rid), .rdata (rdata), .rresp (rresp), .rlast (rlast), .rvalid (rvalid), .rready (rready),
    .tx_data (tx_data), .tx_valid (tx_valid), .tx_ready (tx_ready)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] ar_log[$];
  int done_cnt = 0, drop_cnt = 0, byte_cnt = 0;
  int tx_mode = 0;
  int err_beat = -1;
  logic [7:0] seq_m = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    return a[7:0] ^ {a[12:8], a[15:13]} ^ 8'h5C;
  endfunction

  // AXI slave: RAM model, records every AR, feeds the scoreboard per burst
  initial begin : slave
    logic ar_fire, r_fire, act;
    logic [31:0] a_s, base;
    logic [7:0]  len_s;
    logic [2:0]  size_s;
    logic [1:0]  burst_s;
    int k;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = 4'h0;
    act = 1'b0; k = 0; base = 32'h0;
    forever begin
      @(negedge clk);
      ar_fire = arvalid && arready;
      r_fire  = rvalid && rready;
      a_s = araddr; len_s = arlen; size_s = arsize; burst_s = arburst;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; act = 1'b0; k = 0;
      end else begin
        if (r_fire) begin
          k++;
          if (k == BL) act = 1'b0;
        end
        if (ar_fire) begin
          arready = 1'b0;
          ar_log.push_back(a_s);
          check("arlen", 32'(len_s), 15);
          check("arsize", 32'(size_s), 5);
          check("arburst", 32'(burst_s), 1);
          check("ar_in_ring", 32'((a_s + 32'd512 <= 32'h4000) && (a_s[8:0] == 9'd0)), 1);
          for (int i = 0; i < BL * BB; i++) exp_q.push_back(ram_byte(a_s + 32'(i)));
          base = a_s; k = 0; act = 1'b1;
        end else if (arvalid && !arready) begin
          arready = 1'b1;
        end
        rvalid = act && ($urandom_range(0, 3) != 0);
        if (act) begin
          for (int b = 0; b < BB; b++) rdata[b*8 +: 8] = ram_byte(base + 32'(k * BB + b));
          rlast = (k == BL - 1);
          rresp = (k == err_beat) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  initial begin : txr
    int cyc;
    cyc = 0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      tx_ready = (tx_mode == 0) ? 1'b1 : (cyc % 3 == 0);
    end
  end

  // Output monitor: byte scoreboard, stall hold check, pulse counters
  initial begin : mon
    logic stalled, busy_q;
    logic [7:0] held, e;
    stalled = 1'b0; busy_q = 1'b0; held = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0; busy_q = 1'b0;
      end else begin
`ifdef DUMPER_HEADER_EN
        if (busy && !busy_q) begin
          exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
          exp_q.push_back(seq_m); exp_q.push_back(8'h02);
        end
`endif
        busy_q = busy;
        if (stalled) check("tx_hold", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, held});
        if (tx_valid && tx_ready) begin
          byte_cnt++;
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL tx_extra actual=%0h required=no byte", tx_data);
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", 32'(tx_data), 32'(e));
          end
        end
        stalled = tx_valid && !tx_ready;
        held = tx_data;
        if (done) begin done_cnt++; seq_m++; end
        if (start_drop) drop_cnt++;
      end
    end
  end

  typedef struct {
    logic [31:0] addr;
    int          mode;
    int          err;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        err_exp;
  } vec_t;

  task automatic pulse_start(input logic [31:0] a);
    @(posedge clk); #1;
    read_addr = a; read_start = 1'b1;
    @(posedge clk); #1;
    read_start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check("done_timeout", 32'(done_cnt >= target), 1);
  endtask

  task automatic run_check(input vec_t v);
    int d0, b0, n;
    tx_mode = v.mode; err_beat = v.err;
    ar_log.delete();
    d0 = done_cnt; b0 = byte_cnt;
    pulse_start(v.addr);
    @(negedge clk);
    check("busy_rise", 32'(busy), 1);
    n = 1;
    while (!arvalid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (v.mode == 0) check("ar_latency", 32'(n), 32'(EXP_LAT));
    wait_done(d0 + 1);
    repeat (3) @(posedge clk);
    check("ar_count", 32'(ar_log.size()), 2);
    check("ar_addr0", (ar_log.size() > 0) ? ar_log[0] : 32'hFFFF_FFFF, v.a0);
    check("ar_addr1", (ar_log.size() > 1) ? ar_log[1] : 32'hFFFF_FFFF, v.a1);
    check("byte_count", 32'(byte_cnt - b0), 32'(DUMP_BYTES));
    check("exp_empty", 32'(exp_q.size()), 0);
    check("done_once", 32'(done_cnt - d0), 1);
    check("busy_idle", 32'(busy), 0);
    check("resp_err", 32'(resp_err), 32'(v.err_exp));
    err_beat = -1;
    tx_mode = 0;
  endtask

  initial begin : wdog
    #600000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vt[4];
    int d0, b0, dr0, n;
    vt[0] = '{32'h0000, 0, -1, 32'h0000, 32'h0200, 1'b0};
    vt[1] = '{32'h3E00, 0, -1, 32'h3E00, 32'h0000, 1'b0};
    vt[2] = '{32'h1000, 1, -1, 32'h1000, 32'h1200, 1'b0};
    vt[3] = '{32'h2000, 0,  3, 32'h2000, 32'h2200, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_ctrl", 32'({busy, done, start_drop, resp_err, arvalid, rready, tx_valid}), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_araddr", araddr, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_check(vt[i]);

    // One start, one queued, one dropped
    ar_log.delete();
    d0 = done_cnt; b0 = byte_cnt; dr0 = drop_cnt;
    pulse_start(32'h0000);
    repeat (50) @(posedge clk);
    pulse_start(32'h1000);
    pulse_start(32'h2000);
    wait_done(d0 + 2);
    repeat (3) @(posedge clk);
    check("q_drops", 32'(drop_cnt - dr0), 1);
    check("q_dones", 32'(done_cnt - d0), 2);
    check("q_ar_count", 32'(ar_log.size()), 4);
    check("q_ar2", (ar_log.size() > 2) ? ar_log[2] : 32'hFFFF_FFFF, 32'h1000);
    check("q_ar3", (ar_log.size() > 3) ? ar_log[3] : 32'hFFFF_FFFF, 32'h1200);
    check("q_bytes", 32'(byte_cnt - b0), 32'(2 * DUMP_BYTES));
    check("q_exp_empty", 32'(exp_q.size()), 0);
    check("resp_err_sticky", 32'(resp_err), 1);

    // Start presented in the same cycle as done
    ar_log.delete();
    d0 = done_cnt; dr0 = drop_cnt;
    pulse_start(32'h0800);
    n = 0;
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    read_addr = 32'h1800; read_start = 1'b1;
    @(posedge clk); #1;
    read_start = 1'b0;
    wait_done(d0 + 2);
    repeat (3) @(posedge clk);
    check("dc_ar2", (ar_log.size() > 2) ? ar_log[2] : 32'hFFFF_FFFF, 32'h1800);
    check("dc_drops", 32'(drop_cnt - dr0), 0);
    check("dc_exp_empty", 32'(exp_q.size()), 0);

    // Asynchronous reset in the middle of TX
    d0 = done_cnt; b0 = byte_cnt;
    pulse_start(32'h0000);
    n = 0;
    while ((byte_cnt - b0) < 100 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_ctrl", 32'({busy, done, start_drop, resp_err, arvalid, rready, tx_valid}), 0);
    check("arst_tx_data", 32'(tx_data), 0);
    exp_q.delete();
    seq_m = 8'h00;
    repeat (3) @(posedge clk);
    check("arst_no_done", 32'(done_cnt - d0), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    run_check('{32'h0400, 0, -1, 32'h0400, 32'h0600, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
